// File: rtl/hazard_control_unit_if.sv
// Decode/execute hazard bus: pipeline-side inputs and the controller's stall/flush/branch outputs.
// The master modport is the pipeline side; the slave modport is the hazard controller.
interface hazard_control_unit_if #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 4,
    parameter int OPC_W        = 4,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = 16
);
    logic [OPC_W-1:0]        opcode_decode;
    logic [OPC_W-1:0]        opcode_execute;
    logic                    load_execute;
    logic [REG_AW-1:0]       rd_execute;
    logic [REG_AW-1:0]       rs1_decode;
    logic [REG_AW-1:0]       rs2_decode;
    logic                    rs1_used_decode;
    logic                    rs2_used_decode;
    logic [DATA_W-1:0]       op_a_execute;
    logic [DATA_W-1:0]       op_b_execute;

    logic                    stall;
    logic                    bubble;
    logic [FLUSH_STAGES-1:0] flush;
    logic                    branch_taken;
    logic [CNT_W-1:0]        stall_cycles;
    logic [CNT_W-1:0]        flush_events;

    modport master (
        output opcode_decode, opcode_execute, load_execute, rd_execute,
        output rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
        output op_a_execute, op_b_execute,
        input  stall, bubble, flush, branch_taken, stall_cycles, flush_events
    );

    modport slave (
        input  opcode_decode, opcode_execute, load_execute, rd_execute,
        input  rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode,
        input  op_a_execute, op_b_execute,
        output stall, bubble, flush, branch_taken, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall counter and taken-BEQ flush with a post-flush suppression window.
// Optional saturating performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
    parameter int             DATA_W            = 16,
    parameter int             REG_AW            = 4,
    parameter int             OPC_W             = 4,
    parameter int             LOAD_STALL_CYCLES = 1,
    parameter int             FLUSH_STAGES      = 2,
    parameter logic [OPC_W-1:0] OPC_NOP         = 4'b0000,
    parameter logic [OPC_W-1:0] OPC_BEQ         = 4'b0100,
    parameter int             CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave bus,
    output logic [1:0]           o_dbg_state
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_STALL    = 2'd1;
    localparam logic [1:0] S_SUPPRESS = 2'd2;

    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_STAGES > 1);
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_STAGES - 1);

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [1:0] w_state_nxt;
    logic [2:0] w_cnt_nxt;

    logic                    w_hit;
    logic                    w_take;
    logic                    w_stall;
    logic [FLUSH_STAGES-1:0] w_flush;
    logic                    w_branch;

    // Hazard only if decode really reads the register being loaded.
    assign w_hit = bus.load_execute && (bus.opcode_decode != OPC_NOP) &&
                   ((bus.rs1_used_decode && (bus.rs1_decode == bus.rd_execute)) ||
                    (bus.rs2_used_decode && (bus.rs2_decode == bus.rd_execute)));

    assign w_take = (bus.opcode_execute == OPC_BEQ) &&
                    (bus.op_a_execute == bus.op_b_execute);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = '0;
        w_branch    = 1'b0;
        // A taken branch wins in every state: it aborts a stall or restarts suppression.
        if (w_take) begin
            w_branch = 1'b1;
            w_flush  = '1;
            if (MULTI_FLUSH) begin
                w_state_nxt = S_SUPPRESS;
                w_cnt_nxt   = FLUSH_RELOAD;
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        w_stall = 1'b1;
                        if (MULTI_STALL) begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = STALL_RELOAD;
                        end
                    end
                end
                S_STALL: begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SUPPRESS: begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are killed in the reset cycle itself, not just after the edge.
    assign bus.stall        = rst_n && w_stall;
    assign bus.bubble       = rst_n && w_stall;
    assign bus.flush        = rst_n ? w_flush : '0;
    assign bus.branch_taken = rst_n && w_branch;
    assign o_dbg_state      = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_take && (r_flush_events != {CNT_W{1'b1}})) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with LOAD_STALL_CYCLES=3 and FLUSH_STAGES=3.
// Counter checks follow HAZARD_PERF_CNT_EN.
module tb_hazard_control_unit;
    localparam int DATA_W = 16;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 4;
    localparam int LSC    = 3;
    localparam int FS     = 3;
    localparam int CNT_W  = 16;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b0100;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_SUPPRESS = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_control_unit_if #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W),
        .FLUSH_STAGES(FS), .CNT_W(CNT_W)
    ) bus ();

    hazard_control_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W),
        .LOAD_STALL_CYCLES(LSC), .FLUSH_STAGES(FS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.opcode_decode   = OP_ADD;
        bus.opcode_execute  = OP_ADD;
        bus.load_execute    = 1'b0;
        bus.rd_execute      = 4'd0;
        bus.rs1_decode      = 4'd1;
        bus.rs2_decode      = 4'd2;
        bus.rs1_used_decode = 1'b0;
        bus.rs2_used_decode = 1'b0;
        bus.op_a_execute    = 16'h0000;
        bus.op_b_execute    = 16'h0001;
    endtask

    task automatic set_hit();
        bus.opcode_decode   = OP_ADD;
        bus.load_execute    = 1'b1;
        bus.rd_execute      = 4'd5;
        bus.rs2_decode      = 4'd5;
        bus.rs2_used_decode = 1'b1;
    endtask

    task automatic set_take(input logic [15:0] a, input logic [15:0] b);
        bus.opcode_execute = OP_BEQ;
        bus.op_a_execute   = a;
        bus.op_b_execute   = b;
    endtask

    initial begin
        // Reset with a live hazard and a taken branch on the inputs: outputs stay low.
        quiet();
        set_hit();
        set_take(16'h00aa, 16'h00aa);
        #2;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_branch", 32'(bus.branch_taken), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        quiet();
        #1;
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("rst_flush_events", 32'(bus.flush_events), 32'd0);

        // Load-use on rs2: exactly three stall cycles, then low.
        exp_q = {32'd1, 32'd1, 32'd1, 32'd0};
        set_hit();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            #1;
            chk($sformatf("lu_stall_%0d", i), 32'(bus.stall), e);
            chk($sformatf("lu_bubble_%0d", i), 32'(bus.bubble), e);
            if (i == 1) chk("lu_state_stall", 32'(dbg_state), 32'(ST_STALL));
            tick();
            if (i == 0) quiet();
        end
        chk("lu_state_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Non-hazards: source not used, or decode holds a NOP.
        set_hit();
        bus.rs2_used_decode = 1'b0;
        #1;
        chk("nohit_unused", 32'(bus.stall), 32'd0);
        bus.rs2_used_decode = 1'b1;
        bus.opcode_decode = OP_NOP;
        #1;
        chk("nohit_nop", 32'(bus.stall), 32'd0);
        quiet();

        // rs1 path hazard, then drain the stall.
        bus.load_execute    = 1'b1;
        bus.rd_execute      = 4'd7;
        bus.rs1_decode      = 4'd7;
        bus.rs1_used_decode = 1'b1;
        #1;
        chk("rs1_hit_stall", 32'(bus.stall), 32'd1);
        tick();
        quiet();
        tick();
        tick();
        chk("rs1_drain_state", 32'(dbg_state), 32'(ST_IDLE));

        // Taken branch: one-cycle flush, hazards masked for two cycles.
        set_take(16'h1234, 16'h1234);
        #1;
        chk("beq_flush", 32'(bus.flush), 32'h7);
        chk("beq_branch", 32'(bus.branch_taken), 32'd1);
        tick();
        quiet();
        set_hit();
        #1;
        chk("sup1_state", 32'(dbg_state), 32'(ST_SUPPRESS));
        chk("sup1_stall", 32'(bus.stall), 32'd0);
        chk("sup1_flush", 32'(bus.flush), 32'd0);
        chk("sup1_branch", 32'(bus.branch_taken), 32'd0);
        tick();
        chk("sup2_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("post_sup_stall", 32'(bus.stall), 32'd1);
        tick();
        quiet();
        tick();
        tick();
        chk("post_sup_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Not-taken branches, including a mismatch only in the top bit.
        set_take(16'h1234, 16'h1235);
        #1;
        chk("bne_flush", 32'(bus.flush), 32'd0);
        chk("bne_branch", 32'(bus.branch_taken), 32'd0);
        set_take(16'h8234, 16'h0234);
        #1;
        chk("bne_msb_branch", 32'(bus.branch_taken), 32'd0);
        quiet();

        // Take and hit together in IDLE: branch wins.
        set_hit();
        set_take(16'h0042, 16'h0042);
        #1;
        chk("both_stall", 32'(bus.stall), 32'd0);
        chk("both_branch", 32'(bus.branch_taken), 32'd1);
        tick();
        quiet();
        tick();
        tick();
        chk("both_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Branch on the second cycle of a stall aborts it.
        set_hit();
        #1;
        chk("abort_hit_stall", 32'(bus.stall), 32'd1);
        tick();
        quiet();
        set_take(16'h0005, 16'h0005);
        #1;
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_bubble", 32'(bus.bubble), 32'd0);
        chk("abort_flush", 32'(bus.flush), 32'h7);
        chk("abort_branch", 32'(bus.branch_taken), 32'd1);
        tick();
        quiet();
        chk("abort_state_sup", 32'(dbg_state), 32'(ST_SUPPRESS));
        tick();
        tick();
        chk("abort_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Reset in the middle of a stall.
        set_hit();
        tick();
        chk("rst_mid_state", 32'(dbg_state), 32'(ST_STALL));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(bus.stall), 32'd0);
        chk("rst_mid_bubble", 32'(bus.bubble), 32'd0);
        tick();
        chk("rst_mid_idle", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        quiet();
        #1;

`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_clr_stall", 32'(bus.stall_cycles), 32'd0);
        chk("cnt_clr_flush", 32'(bus.flush_events), 32'd0);
        set_hit();
        tick();
        quiet();
        tick();
        tick();
        chk("cnt_stall3", 32'(bus.stall_cycles), 32'd3);
        set_take(16'h0001, 16'h0001);
        tick();
        quiet();
        chk("cnt_flush1", 32'(bus.flush_events), 32'd1);
        tick();
        tick();
        set_hit();
        repeat ((1 << CNT_W) + 5) tick();
        chk("cnt_stall_sat", 32'(bus.stall_cycles), 32'h0000ffff);
        quiet();
`else
        chk("cnt_off_stall", 32'(bus.stall_cycles), 32'd0);
        chk("cnt_off_flush", 32'(bus.flush_events), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
